mem_requester: RTL and testbench

//  Bus initiator for the 16-bit word memory block. Accepts one read or write request at a time from the core.

---
 rtl/mem_requester.sv | 136 +++++++++++++
 tb/tb_mem_requester.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// Single-outstanding bus initiator between the stack core and the 16-bit word memory.
// Optional MEM_TIMEOUT_EN adds a WAIT-state watchdog that returns an error response.
module mem_requester #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int GUARD_CYCLES = 2
`ifdef MEM_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_rsp;
    logic              w_timeout;
    logic [GW-1:0]     r_guard_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_w;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;
`endif

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_rsp     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_GUARD;
                end
            end
            S_GUARD: begin
                // memory ready is registered, so it may still reflect the previous access here
                if (r_guard_cnt == '0) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    w_rsp  = 1'b1;
                    w_next = S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_guard_cnt <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_w     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
            r_rsp_valid <= w_rsp | w_timeout;
            // write strobe lasts exactly the cycle after accept
            r_mem_w     <= w_accept & req_we;
            if (w_accept) begin
                r_mem_addr  <= req_addr;
                r_mem_wdata <= req_wdata;
                r_guard_cnt <= GUARD_INIT;
            end else if (r_state == S_GUARD && r_guard_cnt != '0) begin
                r_guard_cnt <= r_guard_cnt - 1'b1;
            end
            if (w_rsp) r_rsp_rdata <= mem_rdata;
            if (w_rsp | w_timeout) r_rsp_err <= w_timeout;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == S_GUARD) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT && !mem_ready && r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);
    assign mem_w     = r_mem_w;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a small behavioural word memory.
module tb_mem_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy, mem_w, mem_ready;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_model [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_w) mem_model[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem_model[mem_addr[7:0]];

    mem_requester dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE; lat = edges after accept until rsp_valid, -1 if none.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          input int limit, output int lat, output logic [15:0] rd, output logic err);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0;
        lat = -1; rd = 'x; err = 'x;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        #12;
        total++;
        if ({req_ready, rsp_valid, rsp_err, busy, mem_w} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {req_ready, rsp_valid, rsp_err, busy, mem_w});
        end
        total++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 48'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rsp_rdata});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_early got=%b want=0", req_ready); end
        tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise got=%b want=1", req_ready); end
    endtask

    task automatic test_write;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0002; req_wdata = 16'hBEEF;
        tick();  // edge A
        req_valid = 1'b0;
        total++;
        if ({mem_w, mem_addr, mem_wdata, req_ready, busy} !== {1'b1, 16'h0002, 16'hBEEF, 1'b0, 1'b1}) begin
            bad++; $display("FAIL wr_issue got w=%b a=%h d=%h rdy=%b busy=%b want 1 0002 beef 0 1",
                            mem_w, mem_addr, mem_wdata, req_ready, busy);
        end
        tick();  // A+1
        total++;
        if (mem_w !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL wr_strobe_len got w=%b v=%b want 0 0", mem_w, rsp_valid);
        end
        tick();  // A+2
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%b want=0", rsp_valid); end
        tick();  // A+3
        total++;
        if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 16'hBEEF}) begin
            bad++; $display("FAIL wr_rsp got v=%b e=%b rdy=%b d=%h want 1 0 1 beef",
                            rsp_valid, rsp_err, req_ready, rsp_rdata);
        end
        total++;
        if (mem_model[2] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem got=%h want=beef", mem_model[2]); end
        tick();  // A+4
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hBEEF || mem_addr !== 16'h0002) begin
            bad++; $display("FAIL wr_hold got v=%b d=%h a=%h want 0 beef 0002", rsp_valid, rsp_rdata, mem_addr);
        end
    endtask

    task automatic test_read;
        int lat; logic [15:0] rd; logic err;
        for (int k = 0; k < 2; k++) begin
            do_req(1'b0, 16'h0002, 16'h0000, 20, lat, rd, err);
            total++;
            if (lat !== 3 || rd !== 16'hBEEF || err !== 1'b0) begin
                bad++; $display("FAIL read_%0d got lat=%0d d=%h e=%b want 3 beef 0", k, lat, rd, err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [15:0] rd; logic err;
        do_req(1'b1, 16'h0010, 16'h1111, 20, lat, rd, err);
        do_req(1'b1, 16'h0011, 16'h2222, 20, lat, rd, err);
        total++;
        if (lat !== 3 || rd !== 16'h2222) begin
            bad++; $display("FAIL b2b_prewrite got lat=%0d d=%h want 3 2222", lat, rd);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        tick();  // A
        req_addr = 16'h0011;
        total++;
        if (mem_addr !== 16'h0010 || req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_acc0 got a=%h rdy=%b want 0010 0", mem_addr, req_ready);
        end
        tick(); tick();  // A+2
        total++;
        if (mem_addr !== 16'h0010 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_ignored got a=%h busy=%b want 0010 1", mem_addr, busy);
        end
        tick();  // A+3
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1111) begin
            bad++; $display("FAIL b2b_rsp0 got v=%b d=%h want 1 1111", rsp_valid, rsp_rdata);
        end
        tick();  // A+4
        req_valid = 1'b0;
        total++;
        if (mem_addr !== 16'h0011 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_acc1 got a=%h rdy=%b v=%b want 0011 0 0", mem_addr, req_ready, rsp_valid);
        end
        tick(); tick(); tick();  // A+7
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h2222) begin
            bad++; $display("FAIL b2b_rsp1 got v=%b d=%h want 1 2222", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_stall;
        int lat; logic [15:0] rd; logic err;
        mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
        do_req(1'b0, 16'h0020, 16'h0000, 200, lat, rd, err);
        total++;
        if (lat !== 66 || err !== 1'b1 || rd !== 16'h2222) begin
            bad++; $display("FAIL stall_timeout got lat=%0d e=%b d=%h want 66 1 2222", lat, err, rd);
        end
        mem_ready = 1'b1;
`else
        do_req(1'b0, 16'h0020, 16'h0000, 100, lat, rd, err);
        total++;
        if (lat !== -1 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_hang got lat=%0d busy=%b want -1 1", lat, busy);
        end
        mem_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== mem_model[8'h20]) begin
            bad++; $display("FAIL stall_release got v=%b e=%b d=%h want 1 0 %h",
                            rsp_valid, rsp_err, rsp_rdata, mem_model[8'h20]);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid;
        int seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030; req_wdata = 16'h1234;
        tick();  // A: strobe up, now in GUARD
        req_valid = 1'b0;
        total++;
        if (mem_w !== 1'b1) begin bad++; $display("FAIL rmid_strobe got=%b want=1", mem_w); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_w, busy, req_ready, mem_addr} !== {3'b000, 16'h0000}) begin
            bad++; $display("FAIL rmid_abort got w=%b busy=%b rdy=%b a=%h want 0 0 0 0000",
                            mem_w, busy, req_ready, mem_addr);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (rsp_valid) seen++; end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(); if (rsp_valid) seen++; end
        total++;
        if (seen !== 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_recover got rsp=%0d rdy=%b busy=%b want 0 1 0", seen, req_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
